// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequences MEM-stage loads and stores of the pipelined MIPS core onto a
// word-wide, single-port data memory that has no byte enables and a variable
// response latency. Sub-word loads are extracted and sign/zero extended.
// Sub-word stores are performed as read-modify-write. The pipeline is stalled
// until the access completes or is aborted on a timeout.
//
// Parameters
//   TIMEOUT  ready-low cycles allowed per memory phase before aborting (>= 1)
//   CNT_W    width of the wait counter, 2**CNT_W > TIMEOUT
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   req_valid/req_write     MEM stage holds a memory op / op is a store
//   req_size                00 byte, 01 half, 1x word
//   req_signed              sign-extend sub-word loads
//   req_addr, req_wdata     byte address, right-aligned store data
//   stall                   freeze IF..MEM
//   rdata, done, err        load result, completion pulse, timeout pulse
//   misalign                combinational illegal-alignment flag
//   mem_addr/mem_re/mem_we  word address and registered strobes to dmem
//   mem_wdata               full write word
//   mem_rdata/mem_ready     read word and completion from dmem
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Last counter value that still waits; one more ready-low cycle aborts.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state_reg;
    logic [1:0]         lane_reg;
    logic [1:0]         size_reg;
    logic               signed_reg;
    logic               write_reg;
    logic [15:0]        wdata_reg;
    logic [31:0]        rword_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [31:0]        rdata_reg;
    logic               done_reg;
    logic               err_reg;
    logic [31:0]        mem_addr_reg;
    logic               mem_re_reg;
    logic               mem_we_reg;
    logic [31:0]        mem_wdata_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic req_is_half;
    logic req_is_word;
    logic misaligned;
    logic accept;

    assign req_is_half = (req_size == 2'b01);
    assign req_is_word = req_size[1];
    assign misaligned  = (req_is_half & req_addr[0]) |
                         (req_is_word & (req_addr[1:0] != 2'b00));

    // The reset gate keeps stall low while the block is held in reset.
    assign accept   = (state_reg == IDLE) & req_valid & ~misaligned & reset;
    assign misalign = (state_reg == IDLE) & req_valid & misaligned;

    assign stall = accept | (state_reg == RD) | (state_reg == MERGE) |
                   (state_reg == WR);

    // ------------------------------------------------------------------
    // Load extraction straight from the memory word, so the extended value
    // can be registered on the same edge that mem_ready is seen.
    // ------------------------------------------------------------------
    logic [7:0]  rd_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = rd_lane[lane_reg];
    assign ld_half = lane_reg[1] ? {rd_lane[3], rd_lane[2]}
                                 : {rd_lane[1], rd_lane[0]};

    always_comb begin
        ld_ext = mem_rdata;
        if (!size_reg[1]) begin
            if (size_reg[0]) begin
                ld_ext = {{16{signed_reg & ld_half[15]}}, ld_half};
            end else begin
                ld_ext = {{24{signed_reg & ld_byte[7]}}, ld_byte};
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-modify-write merge: each byte lane of the captured word is either
    // kept or replaced by the matching byte of the store data. Only sub-word
    // stores reach MERGE, so size_reg[0] distinguishes half from byte.
    // ------------------------------------------------------------------
    logic [31:0] merged_word;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_new;

            assign lane_hit = size_reg[0] ? (lane_reg[1] == LANE[1])
                                          : (lane_reg == LANE);
            assign lane_new = (size_reg[0] & LANE[0]) ? wdata_reg[15:8]
                                                      : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = lane_hit ? lane_new
                                                     : rword_reg[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            lane_reg      <= 2'b00;
            size_reg      <= 2'b00;
            signed_reg    <= 1'b0;
            write_reg     <= 1'b0;
            wdata_reg     <= 16'h0000;
            rword_reg     <= 32'h0000_0000;
            wait_cnt_reg  <= '0;
            rdata_reg     <= 32'h0000_0000;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_addr_reg  <= 32'h0000_0000;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= 32'h0000_0000;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        lane_reg     <= req_addr[1:0];
                        size_reg     <= req_size;
                        signed_reg   <= req_signed;
                        write_reg    <= req_write;
                        wdata_reg    <= req_wdata[15:0];
                        mem_addr_reg <= {req_addr[31:2], 2'b00};
                        wait_cnt_reg <= '0;
                        if (req_write && req_is_word) begin
                            // Full-word store needs no read phase.
                            mem_wdata_reg <= req_wdata;
                            mem_we_reg    <= 1'b1;
                            state_reg     <= WR;
                        end else begin
                            mem_re_reg <= 1'b1;
                            state_reg  <= RD;
                        end
                    end
                end

                RD: begin
                    if (mem_ready) begin
                        mem_re_reg <= 1'b0;
                        rword_reg  <= mem_rdata;
                        if (write_reg) begin
                            state_reg <= MERGE;
                        end else begin
                            rdata_reg <= ld_ext;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        // Abort; a pending sub-word store is dropped unwritten.
                        mem_re_reg <= 1'b0;
                        rdata_reg  <= 32'h0000_0000;
                        done_reg   <= 1'b1;
                        err_reg    <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                    end
                end

                MERGE: begin
                    mem_wdata_reg <= merged_word;
                    mem_we_reg    <= 1'b1;
                    wait_cnt_reg  <= '0;
                    state_reg     <= WR;
                end

                WR: begin
                    if (mem_ready) begin
                        mem_we_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        mem_we_reg <= 1'b0;
                        rdata_reg  <= 32'h0000_0000;
                        done_reg   <= 1'b1;
                        err_reg    <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                    end
                end

                DONE: begin
                    // The MEM stage still presents the finished request here;
                    // it is deliberately not re-accepted.
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg  <= IDLE;
                    mem_re_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rdata     = rdata_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Drives directed and random MEM-stage accesses into dmem_access_ctrl while a
// behavioural memory answers mem_re/mem_we after a chosen number of wait
// cycles. Expected load results, memory contents, stall lengths and timeout
// aborts are computed from the access rules at transaction level.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int          vec = 0;
    int          errs = 0;
    int          txn = 0;
    logic [31:0] dmem    [16];   // the memory the DUT talks to
    logic [31:0] ref_mem [16];   // what that memory should contain
    logic [31:0] model_rdata = 32'h0;
    int          rd_delay = 0;
    int          wr_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: ready comes after <delay> low cycles of a strobe
    // phase; outside a phase ready and rdata are random noise.
    initial begin : responder
        bit prev_strobe;
        int pc;
        prev_strobe = 1'b0;
        pc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mem_ready   = 1'b0;
                prev_strobe = 1'b0;
            end else if (mem_re || mem_we) begin
                pc = prev_strobe ? pc + 1 : 0;
                mem_ready = (pc == (mem_re ? rd_delay : wr_delay));
                mem_rdata = (mem_re && mem_ready) ? dmem[mem_addr[5:2]] : $urandom;
                if (mem_we && mem_ready) dmem[mem_addr[5:2]] = mem_wdata;
                prev_strobe = 1'b1;
            end else begin
                prev_strobe = 1'b0;
                mem_ready   = 1'($urandom_range(0, 1));
                mem_rdata   = $urandom;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access, started at posedge+1 with the DUT idle. Returns the DUT's
    // rdata/err seen with done.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int rdl, input int wdl,
                             output logic [31:0] got, output logic got_err);
        int          idx;
        int          sh;
        logic        mis;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] old;
        logic [31:0] shifted;
        logic [31:0] mask;
        int          exp_cyc;
        int          cyc;
        bit          seen;

        idx     = int'(a[5:2]);
        sh      = 8 * int'(a[1:0]);
        old     = ref_mem[idx];
        mis     = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        got     = rdata;
        got_err = 1'b0;
        txn++;

        rd_delay   = rdl;
        wr_delay   = wdl;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;

        if (mis) begin
            @(negedge clk);
            chk("mis_flag", 32'(misalign), 32'd1);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            chk("mis_strobe", {30'b0, mem_re, mem_we}, 32'd0);
            chk("mis_done2", 32'(done), 32'd0);
            @(posedge clk); #1;
            chk("mis_dmem", dmem[idx], ref_mem[idx]);
            $display("txn %0d: misaligned w=%0b size=%0d addr=%08h", txn, w, sz, a);
            return;
        end

        exp_err = 1'b0;
        exp_rd  = model_rdata;
        exp_cyc = 0;
        if (!w) begin
            if (rdl >= TO) begin
                exp_err = 1'b1;
                exp_cyc = 1 + TO;
            end else begin
                exp_cyc = 2 + rdl;
                shifted = old >> sh;
                if (sz == 2'b00)
                    exp_rd = sg ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
                else if (sz == 2'b01)
                    exp_rd = sg ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
                else
                    exp_rd = old;
            end
        end else if (sz[1]) begin
            if (wdl >= TO) begin
                exp_err = 1'b1;
                exp_cyc = 1 + TO;
            end else begin
                exp_cyc = 2 + wdl;
                ref_mem[idx] = wd;
            end
        end else begin
            if (rdl >= TO) begin
                exp_err = 1'b1;
                exp_cyc = 1 + TO;
            end else if (wdl >= TO) begin
                exp_err = 1'b1;
                exp_cyc = 3 + rdl + TO;
            end else begin
                exp_cyc = 4 + rdl + wdl;
                mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                ref_mem[idx] = (old & ~mask) | ((wd << sh) & mask);
            end
        end
        if (exp_err) exp_rd = 32'h0;

        cyc  = 0;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) chk("no_misalign", 32'(misalign), 32'd0);
            chk("strobe_excl", 32'(mem_re & mem_we), 32'd0);
            if (mem_re || mem_we) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("stall_busy", 32'(stall), 32'd1);
            cyc++;
            @(posedge clk); #1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("stall_at_done", 32'(stall), 32'd0);
            chk("err", 32'(err), 32'(exp_err));
            chk("rdata", rdata, exp_rd);
            chk("stall_cycles", 32'(cyc), 32'(exp_cyc));
            got     = rdata;
            got_err = err;
        end
        model_rdata = exp_rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("dmem", dmem[idx], ref_mem[idx]);
        $display("txn %0d: w=%0b size=%0d sg=%0b addr=%08h rdl=%0d wdl=%0d rdata=%08h err=%0b",
                 txn, w, sz, sg, a, rdl, wdl, got, got_err);
    endtask

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5) return 0;
        if (r < 8) return int'($urandom_range(1, 3));
        return int'($urandom_range(4, 6));
    endfunction

    initial begin : main
        logic [31:0] got;
        logic        got_err;
        bit          seen;

        for (int i = 0; i < 16; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[4]    = 32'h12FE_3456;
        ref_mem[4] = 32'h12FE_3456;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", {30'b0, mem_re, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed accesses on the word at 0x50
        do_access(1'b0, 2'b00, 1'b0, 32'h52, 32'h0, 0, 0, got, got_err);
        chk("lit_lbu", got, 32'h0000_00FE);
        do_access(1'b0, 2'b00, 1'b1, 32'h52, 32'h0, 0, 0, got, got_err);
        chk("lit_lb", got, 32'hFFFF_FFFE);
        do_access(1'b0, 2'b01, 1'b1, 32'h50, 32'h0, 0, 0, got, got_err);
        chk("lit_lh", got, 32'h0000_3456);
        do_access(1'b0, 2'b01, 1'b0, 32'h52, 32'h0, 0, 0, got, got_err);
        chk("lit_lhu", got, 32'h0000_12FE);
        do_access(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 0, 0, got, got_err);
        chk("lit_lw", got, 32'h12FE_3456);
        do_access(1'b1, 2'b00, 1'b0, 32'h51, 32'h0000_00AB, 0, 0, got, got_err);
        chk("lit_sb_mem", dmem[4], 32'h12FE_AB56);
        do_access(1'b1, 2'b01, 1'b0, 32'h52, 32'h0000_BEEF, 0, 0, got, got_err);
        chk("lit_sh_mem", dmem[4], 32'hBEEF_AB56);
        do_access(1'b0, 2'b01, 1'b1, 32'h51, 32'h0, 0, 0, got, got_err);
        do_access(1'b1, 2'b11, 1'b0, 32'h56, 32'hDEAD_BEEF, 0, 0, got, got_err);
        chk("lit_mis_mem", dmem[5], ref_mem[5]);
        do_access(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 3, 0, got, got_err);
        chk("lit_lw_wait", got, 32'hBEEF_AB56);
        do_access(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 100, 0, got, got_err);
        chk("lit_timeout_err", 32'(got_err), 32'd1);
        chk("lit_timeout_rdata", got, 32'h0);

        // Reset asserted while an sb is in its write phase
        rd_delay   = 0;
        wr_delay   = 1000;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h51;
        req_wdata  = 32'h0000_0077;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstwr_reach_wr", 32'(seen), 32'd1);
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstwr_we_drop", 32'(mem_we), 32'd0);
        chk("rstwr_stall", 32'(stall), 32'd0);
        chk("rstwr_done", 32'(done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        wr_delay = 0;
        model_rdata = 32'h0;
        @(negedge clk);
        chk("rstwr_idle_stall", 32'(stall), 32'd0);
        chk("rstwr_idle_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("rstwr_mem", dmem[4], 32'hBEEF_AB56);
        do_access(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 0, 0, got, got_err);
        chk("lit_lw_after_rst", got, 32'hBEEF_AB56);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                // Bias toward aligned addresses so most accesses proceed.
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      a, $urandom, rnd_delay(), rnd_delay(), got, got_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
